decodifica_painel: RTL and testbench
====================================

DECODIFICA_PAINEL -- requirements
Module: decodifica_painel

Interface
REQ-001 SHALL have port Clock  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port SerialSeg  input  1  segment bit stream, one segment per cycle, order A,B,C,D,E,F,G.
REQ-004 SHALL have port FrameStart  input  1  high on the cycle SerialSeg carries segment A.
REQ-005 SHALL have port ChaveSeletora  input  1  frame type, sampled with FrameStart: 0 tank frame, 1 irrigation frame.
REQ-006 SHALL have port NivelCaixa  output  2  decoded tank level: 00 empty, 01 low, 10 medium, 11 high.
REQ-007 SHALL have ports Gotejamento and Aspersao  output  1 each  decoded irrigation actuators.
REQ-008 SHALL have port NivelValido  output  1  one-cycle pulse when NivelCaixa updates.
REQ-009 SHALL have port AcionaValido  output  1  one-cycle pulse when Gotejamento/Aspersao update.
REQ-010 SHALL have port ErroQuadro  output  1  one-cycle pulse on aborted or undecodable frame.

Function
REQ-011 SHALL implement FSM states OCIOSO and RECEBE with a 3-bit segment counter 0..6.
REQ-012 In OCIOSO, FrameStart=1 SHALL capture segment A, latch ChaveSeletora, set counter=1, enter RECEBE; SerialSeg otherwise ignored.
REQ-013 In RECEBE each cycle SHALL shift in one bit and increment counter; the cycle capturing G (counter=6) SHALL return to OCIOSO.
REQ-014 FrameStart=1 in RECEBE (including the G cycle) SHALL abort the frame, pulse ErroQuadro next cycle, and restart reception with that bit as segment A.
REQ-015 FrameStart on the cycle immediately after G SHALL start a new frame with no gap or error (back-to-back frames).
REQ-016 Tank patterns (A..G): 1111110->00, 0110000->01, 1101101->10, 1111001->11.
REQ-017 Irrigation patterns (A..G): 0000001->G=0,A=0; 1011110->G=1,A=0; 1110111->G=0,A=1; 1111111->G=1,A=1.
REQ-018 Latency: outputs and valid pulse SHALL appear on the cycle after segment G is sampled (1 cycle).
REQ-019 Pattern not in the table of its frame type SHALL pulse ErroQuadro with 1-cycle latency and leave decoded outputs unchanged.
REQ-020 NivelCaixa, Gotejamento, Aspersao SHALL hold value between updates; NivelValido, AcionaValido, ErroQuadro SHALL never be high for more than one consecutive cycle per event.
REQ-021 Only the output group matching the latched frame type SHALL update; ChaveSeletora changes mid-frame SHALL be ignored.

Reset
REQ-022 Reset_n=0 SHALL immediately force OCIOSO, counter=0, shift register=0, NivelCaixa=00, Gotejamento=0, Aspersao=0, all pulses=0, filter history cleared.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame without ErroQuadro; first FrameStart after release starts a fresh frame.

Configuration
REQ-024 Macro FILTRO_ESTAVEL_EN defined: a valid decoded value SHALL update outputs only when equal to the previous valid frame of the same type; first valid frame after reset only loads history; errored frames clear that type's history.
REQ-025 FILTRO_ESTAVEL_EN undefined: every valid frame SHALL update outputs and pulse its valid signal.

Verification
REQ-026 Reset release, FrameStart with ChaveSeletora=0, stream 1101101 -> next cycle NivelCaixa=10, NivelValido=1 for one cycle (filter off).
REQ-027 ChaveSeletora=1, stream 1110111 -> Aspersao=1, Gotejamento=0, AcionaValido pulse; NivelCaixa unchanged.
REQ-028 FrameStart re-asserted at segment D of a tank frame -> ErroQuadro pulse; restarted frame 0110000 -> NivelCaixa=01.
REQ-029 Tank stream 1010101 -> ErroQuadro pulse, NivelCaixa holds prior value, no NivelValido.
REQ-030 Back-to-back tank frames 1111001,1111001 with FILTRO_ESTAVEL_EN -> first frame no update, second NivelCaixa=11 with NivelValido; without macro both pulse.
REQ-031 Reset_n low at segment E -> all outputs zero immediately; no ErroQuadro after release.

Source files
------------

// File: rtl/decodifica_painel.sv
// -----------------------------------------------------------------------------
// decodifica_painel
//
// Decodes a serial seven-segment stream coming from a control panel. Each
// frame carries segments A..G, one per clock, starting on the cycle where
// FrameStart is high. ChaveSeletora, sampled together with FrameStart, tells
// whether the frame shows the water tank level or the irrigation actuators.
//
// Ports
//   Clock          in   sole clock, rising edge
//   Reset_n        in   asynchronous reset, active-low
//   SerialSeg      in   segment bit stream, order A,B,C,D,E,F,G
//   FrameStart     in   high on the cycle SerialSeg carries segment A
//   ChaveSeletora  in   frame type: 0 tank, 1 irrigation
//   NivelCaixa     out  decoded tank level (00 empty .. 11 high)
//   Gotejamento    out  decoded drip actuator
//   Aspersao       out  decoded sprinkler actuator
//   NivelValido    out  one-cycle pulse when NivelCaixa updates
//   AcionaValido   out  one-cycle pulse when Gotejamento/Aspersao update
//   ErroQuadro     out  one-cycle pulse on aborted or undecodable frame
//
// Optional feature: define FILTRO_ESTAVEL_EN to only accept a decoded value
// once two consecutive valid frames of the same type agree.
// -----------------------------------------------------------------------------
module decodifica_painel (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       SerialSeg,
   input  logic       FrameStart,
   input  logic       ChaveSeletora,
   output logic [1:0] NivelCaixa,
   output logic       Gotejamento,
   output logic       Aspersao,
   output logic       NivelValido,
   output logic       AcionaValido,
   output logic       ErroQuadro
);

   typedef enum logic {OCIOSO = 1'b0, RECEBE = 1'b1} estado_t;

   estado_t    estado, estado_next;
   logic [2:0] contador, contador_next;
   logic [6:0] desloca, desloca_next;
   logic       tipo, tipo_next;
   logic       aborta;
   logic       quadro_fim;
   logic [6:0] quadro;

   logic       tanque_ok;
   logic [1:0] tanque_nivel;
   logic       irrig_ok;
   logic       irrig_got;
   logic       irrig_asp;
   logic       quadro_ok;
   logic       erro_evento;
   logic       valido_evento;
   logic       aplica;

   // State register for the frame receiver.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         estado   <= OCIOSO;
         contador <= 3'd0;
         desloca  <= 7'd0;
         tipo     <= 1'b0;
      end else begin
         estado   <= estado_next;
         contador <= contador_next;
         desloca  <= desloca_next;
         tipo     <= tipo_next;
      end
   end

   // Next-state logic. A FrameStart seen while still receiving aborts the
   // current frame and that same bit becomes segment A of a new frame.
   always_comb begin
      estado_next   = estado;
      contador_next = contador;
      desloca_next  = desloca;
      tipo_next     = tipo;
      aborta        = 1'b0;
      quadro_fim    = 1'b0;
      quadro        = {desloca[5:0], SerialSeg};
      case (estado)
         OCIOSO: begin
            if (FrameStart) begin
               desloca_next  = {6'd0, SerialSeg};
               contador_next = 3'd1;
               tipo_next     = ChaveSeletora;
               estado_next   = RECEBE;
            end
         end
         RECEBE: begin
            if (FrameStart) begin
               aborta        = 1'b1;
               desloca_next  = {6'd0, SerialSeg};
               contador_next = 3'd1;
               tipo_next     = ChaveSeletora;
            end else begin
               desloca_next = quadro;
               if (contador == 3'd6) begin
                  quadro_fim    = 1'b1;
                  contador_next = 3'd0;
                  estado_next   = OCIOSO;
               end else begin
                  contador_next = contador + 3'd1;
               end
            end
         end
         default: estado_next = OCIOSO;
      endcase
   end

   // Pattern tables; the frame word holds A in bit 6 down to G in bit 0.
   always_comb begin
      tanque_ok    = 1'b1;
      tanque_nivel = 2'b00;
      case (quadro)
         7'b1111110: tanque_nivel = 2'b00;
         7'b0110000: tanque_nivel = 2'b01;
         7'b1101101: tanque_nivel = 2'b10;
         7'b1111001: tanque_nivel = 2'b11;
         default:    tanque_ok    = 1'b0;
      endcase
      irrig_ok  = 1'b1;
      irrig_got = 1'b0;
      irrig_asp = 1'b0;
      case (quadro)
         7'b0000001: begin irrig_got = 1'b0; irrig_asp = 1'b0; end
         7'b1011110: begin irrig_got = 1'b1; irrig_asp = 1'b0; end
         7'b1110111: begin irrig_got = 1'b0; irrig_asp = 1'b1; end
         7'b1111111: begin irrig_got = 1'b1; irrig_asp = 1'b1; end
         default:    irrig_ok = 1'b0;
      endcase
   end

   assign quadro_ok     = tipo ? irrig_ok : tanque_ok;
   assign erro_evento   = aborta | (quadro_fim & ~quadro_ok);
   assign valido_evento = quadro_fim & quadro_ok;

`ifdef FILTRO_ESTAVEL_EN
   logic       hist_tanque_ok;
   logic [1:0] hist_tanque;
   logic       hist_irrig_ok;
   logic [1:0] hist_irrig;
   logic       estavel;

   // A value is only applied when it repeats the previous valid frame of the
   // same type. On an abort, tipo still holds the aborted frame's type, so
   // the right history is cleared.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         hist_tanque_ok <= 1'b0;
         hist_tanque    <= 2'b00;
         hist_irrig_ok  <= 1'b0;
         hist_irrig     <= 2'b00;
      end else if (valido_evento) begin
         if (tipo) begin
            hist_irrig_ok <= 1'b1;
            hist_irrig    <= {irrig_got, irrig_asp};
         end else begin
            hist_tanque_ok <= 1'b1;
            hist_tanque    <= tanque_nivel;
         end
      end else if (erro_evento) begin
         if (tipo) hist_irrig_ok  <= 1'b0;
         else      hist_tanque_ok <= 1'b0;
      end
   end

   assign estavel = tipo ? (hist_irrig_ok && (hist_irrig == {irrig_got, irrig_asp}))
                         : (hist_tanque_ok && (hist_tanque == tanque_nivel));
   assign aplica  = valido_evento & estavel;
`else
   assign aplica  = valido_evento;
`endif

   // Decoded outputs hold between updates; the strobes are rebuilt every
   // cycle so they can never stay high longer than one cycle per event.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         NivelCaixa   <= 2'b00;
         Gotejamento  <= 1'b0;
         Aspersao     <= 1'b0;
         NivelValido  <= 1'b0;
         AcionaValido <= 1'b0;
         ErroQuadro   <= 1'b0;
      end else begin
         NivelValido  <= 1'b0;
         AcionaValido <= 1'b0;
         ErroQuadro   <= erro_evento;
         if (aplica) begin
            if (tipo) begin
               Gotejamento  <= irrig_got;
               Aspersao     <= irrig_asp;
               AcionaValido <= 1'b1;
            end else begin
               NivelCaixa  <= tanque_nivel;
               NivelValido <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_decodifica_painel.sv
// -----------------------------------------------------------------------------
// tb_decodifica_painel
//
// Directed bench for decodifica_painel. Every cycle the expected output word
// {NivelCaixa, Gotejamento, Aspersao, NivelValido, AcionaValido, ErroQuadro}
// is pushed to a scoreboard queue before the clock edge and popped and
// compared one time unit after it.
// -----------------------------------------------------------------------------
module tb_decodifica_painel;

   logic       Clock = 1'b0;
   logic       Reset_n = 1'b1;
   logic       SerialSeg = 1'b0;
   logic       FrameStart = 1'b0;
   logic       ChaveSeletora = 1'b0;
   logic [1:0] NivelCaixa;
   logic       Gotejamento;
   logic       Aspersao;
   logic       NivelValido;
   logic       AcionaValido;
   logic       ErroQuadro;

   typedef logic [6:0] obs_t;

   obs_t       esperado_q[$];
   int         check_count = 0;
   int         pass_count = 0;

   logic [1:0] m_nivel;
   logic       m_got;
   logic       m_asp;
   logic       mh_tank_ok;
   logic [1:0] mh_tank;
   logic       mh_irr_ok;
   logic [1:0] mh_irr;

   always #5 Clock = ~Clock;

   decodifica_painel dut (
      .Clock        (Clock),
      .Reset_n      (Reset_n),
      .SerialSeg    (SerialSeg),
      .FrameStart   (FrameStart),
      .ChaveSeletora(ChaveSeletora),
      .NivelCaixa   (NivelCaixa),
      .Gotejamento  (Gotejamento),
      .Aspersao     (Aspersao),
      .NivelValido  (NivelValido),
      .AcionaValido (AcionaValido),
      .ErroQuadro   (ErroQuadro)
   );

   function automatic obs_t held();
      return {m_nivel, m_got, m_asp, 3'b000};
   endfunction

   task automatic resetModel();
      m_nivel    = 2'b00;
      m_got      = 1'b0;
      m_asp      = 1'b0;
      mh_tank_ok = 1'b0;
      mh_tank    = 2'b00;
      mh_irr_ok  = 1'b0;
      mh_irr     = 2'b00;
   endtask

   task automatic clearHist(input logic tipo);
      if (tipo) mh_irr_ok  = 1'b0;
      else      mh_tank_ok = 1'b0;
   endtask

   // Expected result of a completed frame, from the panel pattern tables.
   task automatic modelFim(input logic tipo, input logic [6:0] w);
      logic       ok;
      logic       upd;
      logic [1:0] v;
      ok = 1'b1;
      v  = 2'b00;
      if (!tipo) begin
         case (w)
            7'b1111110: v = 2'b00;
            7'b0110000: v = 2'b01;
            7'b1101101: v = 2'b10;
            7'b1111001: v = 2'b11;
            default:    ok = 1'b0;
         endcase
      end else begin
         case (w)
            7'b0000001: v = 2'b00;
            7'b1011110: v = 2'b10;
            7'b1110111: v = 2'b01;
            7'b1111111: v = 2'b11;
            default:    ok = 1'b0;
         endcase
      end
      if (!ok) begin
         clearHist(tipo);
         esperado_q.push_back(held() | 7'b0000001);
      end else begin
         upd = 1'b1;
`ifdef FILTRO_ESTAVEL_EN
         if (tipo) begin
            upd       = mh_irr_ok && (mh_irr == v);
            mh_irr    = v;
            mh_irr_ok = 1'b1;
         end else begin
            upd        = mh_tank_ok && (mh_tank == v);
            mh_tank    = v;
            mh_tank_ok = 1'b1;
         end
`endif
         if (!upd) begin
            esperado_q.push_back(held());
         end else if (tipo) begin
            {m_got, m_asp} = v;
            esperado_q.push_back(held() | 7'b0000010);
         end else begin
            m_nivel = v;
            esperado_q.push_back(held() | 7'b0000100);
         end
      end
   endtask

   task automatic checkOutput(input string tag, input obs_t exp);
      obs_t obs;
      obs = {NivelCaixa, Gotejamento, Aspersao, NivelValido, AcionaValido, ErroQuadro};
      check_count++;
      assert (obs === exp) pass_count++;
      else $error("[TB] FAIL %s: observed %b required %b", tag, obs, exp);
   endtask

   task automatic clockAndScore(input string tag);
      @(posedge Clock);
      #1;
      if (esperado_q.size() == 0) begin
         check_count++;
         $error("[TB] FAIL %s: observed empty scoreboard required pending entry", tag);
      end else begin
         checkOutput(tag, esperado_q.pop_front());
      end
   endtask

   task automatic applyStimulus(input logic fs, input logic ch, input logic b);
      FrameStart    = fs;
      ChaveSeletora = ch;
      SerialSeg     = b;
   endtask

   // Sends the first nbits segments of w. ChaveSeletora is flipped after
   // segment A so a mid-frame change must be ignored. With aborta set, the
   // first bit lands while a previous frame of type tipo_ant is in progress.
   task automatic sendFrame(input logic tipo, input logic [6:0] w, input int nbits,
                            input bit aborta, input logic tipo_ant, input string tag);
      for (int i = 0; i < nbits; i++) begin
         applyStimulus(i == 0, (i == 0) ? tipo : ~tipo, w[6-i]);
         if (i == 0 && aborta) begin
            clearHist(tipo_ant);
            esperado_q.push_back(held() | 7'b0000001);
         end else if (i == 6) begin
            modelFim(tipo, w);
         end else begin
            esperado_q.push_back(held());
         end
         clockAndScore($sformatf("%s_seg%0d", tag, i));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         esperado_q.push_back(held());
         clockAndScore("ocioso");
      end
   endtask

   initial begin
      resetModel();
      applyStimulus(1'b0, 1'b0, 1'b0);
      #2 Reset_n = 1'b0;
      #1 checkOutput("reset_inicial", 7'b0000000);
      repeat (2) @(posedge Clock);
      #1 checkOutput("reset_mantido", 7'b0000000);
      Reset_n = 1'b1;
      idle(3);

      sendFrame(1'b0, 7'b1101101, 7, 1'b0, 1'b0, "tanque_medio");
      idle(2);
      sendFrame(1'b1, 7'b1110111, 7, 1'b0, 1'b0, "irrig_aspersao");
      idle(1);

      sendFrame(1'b0, 7'b1111110, 3, 1'b0, 1'b0, "tanque_parcial");
      sendFrame(1'b0, 7'b0110000, 7, 1'b1, 1'b0, "tanque_reinicio");
      idle(2);

      sendFrame(1'b0, 7'b1010101, 7, 1'b0, 1'b0, "tanque_invalido");
      idle(1);

      sendFrame(1'b0, 7'b1111001, 7, 1'b0, 1'b0, "seguido_1");
      sendFrame(1'b0, 7'b1111001, 7, 1'b0, 1'b0, "seguido_2");
      idle(2);

      sendFrame(1'b1, 7'b1011110, 7, 1'b0, 1'b0, "irrig_gotej");
      sendFrame(1'b1, 7'b1011110, 7, 1'b0, 1'b0, "irrig_gotej_rep");
      sendFrame(1'b1, 7'b0000001, 7, 1'b0, 1'b0, "irrig_desligado");
      idle(1);
      sendFrame(1'b1, 7'b1010101, 7, 1'b0, 1'b0, "irrig_invalido");
      sendFrame(1'b1, 7'b1111111, 7, 1'b0, 1'b0, "irrig_ambos");
      sendFrame(1'b1, 7'b1111111, 7, 1'b0, 1'b0, "irrig_ambos_rep");
      idle(1);

      sendFrame(1'b0, 7'b1111110, 6, 1'b0, 1'b0, "tanque_ate_f");
      sendFrame(1'b1, 7'b0000001, 7, 1'b1, 1'b0, "aborto_em_g");
      idle(1);

      sendFrame(1'b0, 7'b1111001, 4, 1'b0, 1'b0, "reset_parcial");
      #2 Reset_n = 1'b0;
      resetModel();
      #1 checkOutput("reset_meio_quadro", 7'b0000000);
      repeat (2) @(posedge Clock);
      #1 checkOutput("reset_meio_mantido", 7'b0000000);
      Reset_n = 1'b1;
      idle(3);
      sendFrame(1'b0, 7'b0110000, 7, 1'b0, 1'b0, "pos_reset");
      sendFrame(1'b0, 7'b0110000, 7, 1'b0, 1'b0, "pos_reset_rep");
      idle(2);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
